// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 255;
   localparam int unsigned REG_W           = 5;
   localparam int unsigned WD_W            = 8;
   localparam int unsigned CNT_W           = 16;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ISTALL = 2'd1,
      ST_DSTALL = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE    = 3'd0,
      CAUSE_DSTALL  = 3'd1,
      CAUSE_LOADUSE = 3'd2,
      CAUSE_BRANCH  = 3'd3,
      CAUSE_ISTALL  = 3'd4,
      CAUSE_HALT    = 3'd5
   } cause_t;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_write;
      logic exmem_write;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_flush;
      logic imem_abort;
   } ctrl_t;

   typedef struct packed {
      cause_t cause;
      ctrl_t  ctrl;
   } decode_t;

   // Free-running pipeline: every stage advances, nothing squashed.
   localparam ctrl_t CTRL_RUN = '{
      pc_write:    1'b1,
      ifid_write:  1'b1,
      idex_write:  1'b1,
      exmem_write: 1'b1,
      ifid_flush:  1'b0,
      idex_flush:  1'b0,
      memwb_flush: 1'b0,
      imem_abort:  1'b0
   };

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones.
module sat_counter16
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: prioritised hazard decode, stall watchdog
// with sticky halt, and saturating stall/flush statistics.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IDEX_MemRead,
   input  logic [REG_W-1:0] IDEX_rt,
   input  logic [REG_W-1:0] IFID_rs,
   input  logic [REG_W-1:0] IFID_rt,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IDEX_Write,
   output logic             EXMEM_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             MEMWB_Flush,
   output logic             imem_abort,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

   // Highest-priority hazard wins; a masked branch is simply re-presented later.
   function automatic decode_t hazard_decode(
      input state_t           st,
      input logic             mem_read,
      input logic [REG_W-1:0] ex_rt,
      input logic [REG_W-1:0] id_rs,
      input logic [REG_W-1:0] id_rt,
      input logic             br_taken,
      input logic             i_ready,
      input logic             d_req,
      input logic             d_ready
   );
      decode_t d;
      logic    load_use;
      d.cause  = CAUSE_NONE;
      d.ctrl   = CTRL_RUN;
      load_use = mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
      if (st == ST_HALT) begin
         d.cause = CAUSE_HALT;
         d.ctrl  = '0;
      end else if (d_req && !d_ready) begin
         d.cause            = CAUSE_DSTALL;
         d.ctrl.pc_write    = 1'b0;
         d.ctrl.ifid_write  = 1'b0;
         d.ctrl.idex_write  = 1'b0;
         d.ctrl.exmem_write = 1'b0;
         d.ctrl.memwb_flush = 1'b1;
      end else if (load_use) begin
         d.cause            = CAUSE_LOADUSE;
         d.ctrl.pc_write    = 1'b0;
         d.ctrl.ifid_write  = 1'b0;
         d.ctrl.idex_flush  = 1'b1;
      end else if (br_taken) begin
         d.cause            = CAUSE_BRANCH;
         d.ctrl.ifid_flush  = 1'b1;
         d.ctrl.imem_abort  = 1'b1;
      end else if (!i_ready) begin
         d.cause            = CAUSE_ISTALL;
         d.ctrl.pc_write    = 1'b0;
         d.ctrl.ifid_flush  = 1'b1;
      end
      return d;
   endfunction

   state_t          state;
   state_t          state_nxt;
   logic [WD_W-1:0] wd;
   logic [WD_W-1:0] wd_nxt;
   logic            err_nxt;
   decode_t         dec;
   state_t          stall_state;
   logic            mem_stall;
   logic            stall_inc;
   logic            flush_inc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_RUN;
         wd          <= '0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wd          <= wd_nxt;
         err_timeout <= err_nxt;
      end
   end

   always_comb begin
      dec = hazard_decode(state, IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt,
                          branch_taken, imem_ready, dmem_req, dmem_ready);

      PC_Write    = dec.ctrl.pc_write;
      IFID_Write  = dec.ctrl.ifid_write;
      IDEX_Write  = dec.ctrl.idex_write;
      EXMEM_Write = dec.ctrl.exmem_write;
      IFID_Flush  = dec.ctrl.ifid_flush;
      IDEX_Flush  = dec.ctrl.idex_flush;
      MEMWB_Flush = dec.ctrl.memwb_flush;
      imem_abort  = dec.ctrl.imem_abort;

      state_nxt   = state;
      wd_nxt      = wd;
      err_nxt     = err_timeout;
      stall_state = ST_RUN;
      mem_stall   = 1'b0;

      case (dec.cause)
         CAUSE_DSTALL: begin
            mem_stall   = 1'b1;
            stall_state = ST_DSTALL;
         end
         CAUSE_ISTALL: begin
            mem_stall   = 1'b1;
            stall_state = ST_ISTALL;
         end
         default: ;
      endcase

      // Watchdog tracks consecutive cycles of the same memory-stall cause.
      if (state != ST_HALT) begin
         if (mem_stall) begin
            wd_nxt = (state == stall_state) ? wd + WD_W'(1) : WD_W'(1);
            if (wd == WD_LIMIT) begin
               state_nxt = ST_HALT;
               err_nxt   = 1'b1;
            end else begin
               state_nxt = stall_state;
            end
         end else begin
            wd_nxt    = '0;
            state_nxt = ST_RUN;
         end
      end

      stall_inc = (dec.cause == CAUSE_DSTALL) || (dec.cause == CAUSE_LOADUSE) ||
                  (dec.cause == CAUSE_ISTALL);
      flush_inc = (dec.cause == CAUSE_BRANCH);
   end

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (TIMEOUT 255 and 4) on shared
// inputs, checked against a streak-counting reference model.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       IDEX_MemRead;
   logic [4:0] IDEX_rt;
   logic [4:0] IFID_rs;
   logic [4:0] IFID_rt;
   logic       branch_taken;
   logic       imem_ready;
   logic       dmem_req;
   logic       dmem_ready;

   logic        a_pcw, a_ifw, a_idw, a_exw, a_iff, a_idf, a_mwf, a_abt, a_err;
   logic [15:0] a_stall, a_flush;
   logic        b_pcw, b_ifw, b_idw, b_exw, b_iff, b_idf, b_mwf, b_abt, b_err;
   logic [15:0] b_stall, b_flush;
   logic [7:0]  a_ctrl, b_ctrl;

   assign a_ctrl = {a_pcw, a_ifw, a_idw, a_exw, a_iff, a_idf, a_mwf, a_abt};
   assign b_ctrl = {b_pcw, b_ifw, b_idw, b_exw, b_iff, b_idf, b_mwf, b_abt};

   pipe_hazard_ctrl #(.TIMEOUT(255)) dut_a (
      .clk(clk), .rst(rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .PC_Write(a_pcw), .IFID_Write(a_ifw), .IDEX_Write(a_idw), .EXMEM_Write(a_exw),
      .IFID_Flush(a_iff), .IDEX_Flush(a_idf), .MEMWB_Flush(a_mwf), .imem_abort(a_abt),
      .err_timeout(a_err), .stall_cycles(a_stall), .flush_count(a_flush)
   );

   pipe_hazard_ctrl #(.TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .PC_Write(b_pcw), .IFID_Write(b_ifw), .IDEX_Write(b_idw), .EXMEM_Write(b_exw),
      .IFID_Flush(b_iff), .IDEX_Flush(b_idf), .MEMWB_Flush(b_mwf), .imem_abort(b_abt),
      .err_timeout(b_err), .stall_cycles(b_stall), .flush_count(b_flush)
   );

   // Expected control vectors {PC,IFID,IDEX,EXMEM writes, IFID,IDEX,MEMWB flush, abort}.
   localparam logic [7:0] C_HALT = 8'b0000_0000;
   localparam logic [7:0] C_DST  = 8'b0000_0010;
   localparam logic [7:0] C_LU   = 8'b0011_0100;
   localparam logic [7:0] C_BR   = 8'b1111_1001;
   localparam logic [7:0] C_IST  = 8'b0111_1000;
   localparam logic [7:0] C_RUN  = 8'b1111_0000;

   localparam int K_D = 1, K_L = 2, K_B = 3, K_I = 4, K_N = 5;

   int total = 0;
   int bad   = 0;

   int tmo [2] = '{255, 4};
   bit m_halt [2];
   int m_last [2];
   int m_streak [2];
   int m_stall [2];
   int m_flush [2];

   function automatic int classify();
      if (dmem_req && !dmem_ready) return K_D;
      if (IDEX_MemRead && IDEX_rt != 5'd0 && (IDEX_rt == IFID_rs || IDEX_rt == IFID_rt))
         return K_L;
      if (branch_taken) return K_B;
      if (!imem_ready) return K_I;
      return K_N;
   endfunction

   function automatic logic [7:0] exp_ctrl(input int i);
      if (m_halt[i]) return C_HALT;
      case (classify())
         K_D:     return C_DST;
         K_L:     return C_LU;
         K_B:     return C_BR;
         K_I:     return C_IST;
         default: return C_RUN;
      endcase
   endfunction

   task automatic set_idle();
      IDEX_MemRead = 1'b0; IDEX_rt = 5'd0; IFID_rs = 5'd0; IFID_rt = 5'd0;
      branch_taken = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
   endtask

   // One rising edge; the model applies the rules to the inputs present at it.
   task automatic tick();
      int k;
      k = classify();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            m_halt[i] = 0; m_last[i] = 0; m_streak[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
         end else if (!m_halt[i]) begin
            if ((k == K_D || k == K_L || k == K_I) && m_stall[i] < 65535) m_stall[i]++;
            if (k == K_B && m_flush[i] < 65535) m_flush[i]++;
            if (k == K_D || k == K_I) begin
               if (m_streak[i] == tmo[i] - 1) m_halt[i] = 1;
               m_streak[i] = (m_last[i] == k) ? m_streak[i] + 1 : 1;
               m_last[i]   = k;
            end else begin
               m_last[i] = 0; m_streak[i] = 0;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_idle();
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL reset_ctrl_a got=%b exp=%b", a_ctrl, C_RUN); end
      total++; if (b_ctrl !== C_RUN) begin bad++; $display("FAIL reset_ctrl_b got=%b exp=%b", b_ctrl, C_RUN); end
      total++; if (a_stall !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", a_stall); end
      total++; if (a_flush !== 16'd0) begin bad++; $display("FAIL reset_flush got=%0d exp=0", a_flush); end
      total++; if (a_err !== 1'b0 || b_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", a_err, b_err); end
   endtask

   task automatic test_load_use();
      do_reset();
      IDEX_MemRead = 1'b1; IDEX_rt = 5'd5; IFID_rs = 5'd5; IFID_rt = 5'd7;
      #1;
      total++; if (a_ctrl !== C_LU) begin bad++; $display("FAIL load_use_ctrl got=%b exp=%b", a_ctrl, C_LU); end
      tick();
      set_idle();
      #1;
      total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL load_use_release got=%b exp=%b", a_ctrl, C_RUN); end
      total++; if (a_stall !== 16'd1) begin bad++; $display("FAIL load_use_stall got=%0d exp=1", a_stall); end
   endtask

   task automatic test_rt_zero();
      do_reset();
      IDEX_MemRead = 1'b1; IDEX_rt = 5'd0; IFID_rs = 5'd0; IFID_rt = 5'd0;
      #1;
      total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL rt_zero_ctrl got=%b exp=%b", a_ctrl, C_RUN); end
      tick();
      total++; if (a_stall !== 16'd0) begin bad++; $display("FAIL rt_zero_stall got=%0d exp=0", a_stall); end
   endtask

   task automatic test_timeout();
      do_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         total++; if (b_ctrl !== C_DST) begin bad++; $display("FAIL timeout_stall%0d got=%b exp=%b", c, b_ctrl, C_DST); end
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         #1;
         total++; if (b_ctrl !== C_HALT || b_err !== 1'b1) begin
            bad++; $display("FAIL timeout_halt%0d got=%b err=%b exp=%b err=1", c, b_ctrl, b_err, C_HALT);
         end
         total++; if (a_ctrl !== C_DST) begin bad++; $display("FAIL timeout_a_still_stall got=%b exp=%b", a_ctrl, C_DST); end
         tick();
      end
      total++; if (b_stall !== 16'd4) begin bad++; $display("FAIL timeout_stall_count got=%0d exp=4", b_stall); end
      set_idle();
      branch_taken = 1'b1;
      #1;
      total++; if (b_ctrl !== C_HALT) begin bad++; $display("FAIL halt_branch got=%b exp=%b", b_ctrl, C_HALT); end
      tick();
      total++; if (b_flush !== 16'd0) begin bad++; $display("FAIL halt_flush got=%0d exp=0", b_flush); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      set_idle();
      #1;
      total++; if (b_ctrl !== C_RUN || b_err !== 1'b0) begin
         bad++; $display("FAIL halt_exit got=%b err=%b exp=%b err=0", b_ctrl, b_err, C_RUN);
      end
   endtask

   task automatic test_branch_istall();
      do_reset();
      branch_taken = 1'b1; imem_ready = 1'b0;
      #1;
      total++; if (a_ctrl !== C_BR) begin bad++; $display("FAIL branch_ctrl got=%b exp=%b", a_ctrl, C_BR); end
      tick();
      total++; if (a_flush !== 16'd1 || a_stall !== 16'd0) begin
         bad++; $display("FAIL branch_counts got=%0d/%0d exp=1/0", a_flush, a_stall);
      end
   endtask

   task automatic test_priority();
      do_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0; IDEX_MemRead = 1'b1; IDEX_rt = 5'd3;
      IFID_rs = 5'd3; branch_taken = 1'b1; imem_ready = 1'b0;
      #1;
      total++; if (a_ctrl !== C_DST) begin bad++; $display("FAIL priority_ctrl got=%b exp=%b", a_ctrl, C_DST); end
      tick();
      set_idle();
      dmem_req = 1'b0; IDEX_MemRead = 1'b1; IDEX_rt = 5'd3; IFID_rt = 5'd3; branch_taken = 1'b1;
      #1;
      total++; if (a_ctrl !== C_LU) begin bad++; $display("FAIL priority_lu_ctrl got=%b exp=%b", a_ctrl, C_LU); end
      tick();
      total++; if (a_flush !== 16'd0 || a_stall !== 16'd2) begin
         bad++; $display("FAIL priority_counts got=%0d/%0d exp=0/2", a_flush, a_stall);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(99) != 0);
         dmem_req     = ($urandom_range(3) == 0);
         dmem_ready   = $urandom_range(1) == 1;
         IDEX_MemRead = ($urandom_range(2) == 0);
         IDEX_rt      = 5'($urandom_range(3));
         IFID_rs      = 5'($urandom_range(3));
         IFID_rt      = 5'($urandom_range(3));
         branch_taken = ($urandom_range(4) == 0);
         imem_ready   = ($urandom_range(3) != 0);
         #1;
         total++; if (a_ctrl !== exp_ctrl(0)) begin bad++; $display("FAIL rand_ctrl_a n=%0d got=%b exp=%b", n, a_ctrl, exp_ctrl(0)); end
         total++; if (b_ctrl !== exp_ctrl(1)) begin bad++; $display("FAIL rand_ctrl_b n=%0d got=%b exp=%b", n, b_ctrl, exp_ctrl(1)); end
         tick();
         total++; if (a_stall !== 16'(m_stall[0]) || a_flush !== 16'(m_flush[0]) || a_err !== m_halt[0]) begin
            bad++; $display("FAIL rand_regs_a n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, a_stall, a_flush, a_err, m_stall[0], m_flush[0], m_halt[0]);
         end
         total++; if (b_stall !== 16'(m_stall[1]) || b_flush !== 16'(m_flush[1]) || b_err !== m_halt[1]) begin
            bad++; $display("FAIL rand_regs_b n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, b_stall, b_flush, b_err, m_stall[1], m_flush[1], m_halt[1]);
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_saturate();
      int istalls;
      do_reset();
      istalls = 0;
      for (int n = 0; istalls < 70000; n++) begin
         imem_ready = (n % 200 == 199);
         if (!imem_ready) istalls++;
         tick();
      end
      imem_ready = 1'b0;
      #1;
      total++; if (a_stall !== 16'hFFFF) begin bad++; $display("FAIL sat_stall got=%h exp=ffff", a_stall); end
      total++; if (a_err !== 1'b0 || a_ctrl !== C_IST) begin
         bad++; $display("FAIL sat_no_halt got=%b err=%b exp=%b err=0", a_ctrl, a_err, C_IST);
      end
      total++; if (b_err !== m_halt[1]) begin bad++; $display("FAIL sat_b_err got=%b exp=%b", b_err, m_halt[1]); end
   endtask

   initial begin
      rst = 1'b0;
      set_idle();
      test_reset();
      test_load_use();
      test_rt_zero();
      test_timeout();
      test_branch_istall();
      test_priority();
      test_random();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255 (range 2..255): maximum consecutive memory-stall cycles before halt.
REQ-002 SHALL have ports as follows:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_rt  in  5  load destination register.
- IFID_rs, IFID_rt  in  5 each  source registers of the instruction in ID.
- branch_taken  in  1  branch/jump resolved taken in ID this cycle.
- imem_ready  in  1  instruction fetch completes this cycle.
- dmem_req  in  1  MEM stage issues a data access.
- dmem_ready  in  1  data access completes this cycle.
- PC_Write, IFID_Write, IDEX_Write, EXMEM_Write  out  1 each  register enables.
- IFID_Flush, IDEX_Flush, MEMWB_Flush  out  1 each  load NOP/zero controls.
- imem_abort  out  1  abandon the wrong-path fetch.
- err_timeout  out  1  sticky watchdog error.
- stall_cycles  out  16  saturating stall counter.
- flush_count  out  16  saturating branch-flush counter.

Function
REQ-003 SHALL implement states RUN, ISTALL, DSTALL and HALT in a state register.
REQ-004 SHALL compute all enable/flush outputs combinationally from current inputs and state, with zero latency, under the priority in REQ-005..REQ-010.
REQ-005 HALT: all *_Write=0, all flushes=0, imem_abort=0.
REQ-006 Dstall (dmem_req & !dmem_ready): PC/IFID/IDEX/EXMEM_Write=0, MEMWB_Flush=1.
REQ-007 Load-use (IDEX_MemRead & IDEX_rt!=0 & (IDEX_rt==IFID_rs | IDEX_rt==IFID_rt)): PC_Write=0, IFID_Write=0, IDEX_Write=1, IDEX_Flush=1, EXMEM_Write=1.
REQ-008 branch_taken: all *_Write=1, IFID_Flush=1, imem_abort=1; imem_ready is ignored this cycle.
REQ-009 Istall (!imem_ready): PC_Write=0, IFID_Write=1, IFID_Flush=1, IDEX/EXMEM_Write=1.
REQ-010 Otherwise: all *_Write=1, all flushes=0, imem_abort=0.
REQ-011 Any flush/enable not listed for a case SHALL be 0 for flushes and 1 for writes (HALT excepted).
REQ-012 Next state SHALL be:
- DSTALL after a dstall cycle.
- ISTALL after an istall cycle.
- RUN after any other non-HALT cycle.
- HALT is absorbing until reset.
REQ-013 SHALL keep an 8-bit watchdog counter: increment on a dstall/istall cycle whose cause equals the current state; clear to 1 on a cause change; clear to 0 otherwise.
REQ-014 A dstall/istall cycle with watchdog==TIMEOUT-1 SHALL move to HALT and set err_timeout from the next cycle.
REQ-015 stall_cycles SHALL increment on each dstall, load-use or istall cycle outside HALT, and saturate at 0xFFFF.
REQ-016 flush_count SHALL increment on each branch_taken cycle outside HALT (even if masked by dstall/load-use priority: no), and saturate at 0xFFFF.
REQ-017 A branch_taken masked by dstall or load-use SHALL NOT count and SHALL NOT assert flush; the ID stage holds and re-presents it.

Reset
REQ-018 On rst=0 at a rising edge: state=RUN, watchdog=0, err_timeout=0, stall_cycles=0, flush_count=0.
REQ-019 Reset SHALL exit HALT and abort any stall in progress; combinational outputs follow REQ-010 semantics from the first post-reset cycle given idle inputs.

Structure
REQ-020 A shared package SHALL hold the state enumeration (2-bit) and TIMEOUT default constant.
REQ-021 The hazard/priority decode SHALL be a combinational function in the top module; the saturating 16-bit counter SHALL be one sub-module, sat_counter16, instantiated twice.

Verification
REQ-022 Load-use: IDEX_MemRead=1, IDEX_rt=5, IFID_rs=5, imem_ready=1 -> PC_Write=0, IFID_Write=0, IDEX_Flush=1 for one cycle; stall_cycles=1.
REQ-023 IDEX_rt=0 with IFID_rs=0, MemRead=1 -> no stall, all writes 1.
REQ-024 TIMEOUT=4, dmem_req=1, dmem_ready=0 held -> four stall cycles, then HALT, err_timeout=1, all writes 0 until rst=0.
REQ-025 branch_taken=1 with imem_ready=0 -> IFID_Flush=1, PC_Write=1, imem_abort=1, next state RUN, flush_count=1.
REQ-026 Simultaneous dstall, load-use and branch_taken -> dstall outputs only; flush_count unchanged.
REQ-027 Drive 70000 istall cycles with TIMEOUT=255 via intermittent imem_ready pulses -> stall_cycles saturates at 0xFFFF, no HALT.
